// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the line levels
// used for idle/stop and start bits.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/ce_uart_tx_if.sv
// Parallel-side handshake of the UART transmitter.
// Handshake: a word transfers on every rising clk edge where tx_valid and
// tx_ready are both high. tx_data is only looked at on that edge; the producer
// may change or drop tx_valid/tx_data freely while tx_ready is low.
interface ce_uart_tx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/ce_uart_tx.sv
// Serial transmitter driven by a baud-rate clock enable. Bytes arrive over the
// ce_uart_tx_if handshake and leave LSB-first on tx, one bit per baud_ce.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the last data bit and the stop bit(s) (PARITY_ODD selects odd parity).
module ce_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       baud_ce,
   ce_uart_tx_if.slave bus,
   output logic       tx,
   output logic       busy,
   output tx_state_t  state_dbg
);

   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic                 stopcnt_q, stopcnt_d;
   logic                 tx_q, tx_d;

`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`else
   // PARITY_ODD only matters when the parity bit is compiled in.
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   // State, shifter, counters and the registered line output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         stopcnt_q <= 1'b0;
         tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         stopcnt_q <= stopcnt_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Next-state and next line level; everything except the accept in IDLE
   // moves only on baud_ce, so the bits stay on the baud grid.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      stopcnt_d = stopcnt_q;
      tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = UART_IDLE_LEVEL;
            // Accept ignores baud_ce; ALIGN waits for the next pulse so the
            // start bit always lasts a full bit period.
            if (bus.tx_valid) begin
               shift_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
               par_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
`endif
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            if (baud_ce) begin
               tx_d    = UART_START_LEVEL;
               state_d = START;
            end
         end
         START: begin
            if (baud_ce) begin
               tx_d     = shift_q[0];
               bitcnt_d = '0;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (baud_ce) begin
               if (bitcnt_q == BIT_LAST) begin
                  stopcnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  tx_d      = par_q;
                  state_d   = PARITY;
`else
                  tx_d      = UART_IDLE_LEVEL;
                  state_d   = STOP;
`endif
               end else begin
                  shift_d  = shift_q >> 1;
                  tx_d     = shift_q[1];
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
         end
         PARITY: begin
`ifdef UART_TX_PARITY_EN
            if (baud_ce) begin
               tx_d    = UART_IDLE_LEVEL;
               state_d = STOP;
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (baud_ce) begin
               if (stopcnt_q == STOP_LAST) begin
                  state_d = IDLE;
               end else begin
                  stopcnt_d = stopcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign tx           = tx_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_ce_uart_tx.sv
// Bench for ce_uart_tx: two instances (inst0: STOP_BITS=1 PARITY_ODD=0,
// inst1: STOP_BITS=2 PARITY_ODD=1) share clk, reset_n and baud_ce.
// A frame-level reference model predicts tx/busy/tx_ready every clock.
module tb_ce_uart_tx;
   import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic baud_ce = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      tx_valid_a = '0;
   logic [1:0][7:0] tx_data_a  = '0;
   logic [1:0]      tx_w, busy_w, ready_w;
   tx_state_t       dbg_w [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ce_uart_tx_if #(.DATA_BITS(8)) bus ();
      assign bus.tx_data  = tx_data_a[g];
      assign bus.tx_valid = tx_valid_a[g];
      assign ready_w[g]   = bus.tx_ready;
      ce_uart_tx #(.DATA_BITS(8), .STOP_BITS(g + 1), .PARITY_ODD(g)) dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .baud_ce   (baud_ce),
         .bus       (bus),
         .tx        (tx_w[g]),
         .busy      (busy_w[g]),
         .state_dbg (dbg_w[g])
      );
   end

   // ---------------- scoreboard / model state ----------------
   int checks = 0;
   int failures = 0;
   // entry: {is_start_bit, busy_after_this_edge, line_level}
   logic [2:0]  exp_q [2][$];
   int          start_q [2][$];
   logic [1:0]  exp_tx = 2'b11;
   logic [1:0]  exp_busy = 2'b00;
   int          baud_idx [2];
   int          low_clks [2];
   logic [11:0] pend_frame [2];
   int          pend_len [2];
   bit          accepted [2];
   int          ce_div = 4;
   int          ce_cnt = 0;

   typedef struct {
      int          inst;
      logic [7:0]  data;
      int          ce_div;
      logic [11:0] frame;   // bit 0 is sent first
      int          len;
      int          exp_low; // clocks with tx low during the frame
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, i, $time, act, exp);
      end
   endtask

   // Frame from the line rules: start(0), data LSB first, [parity], stop bits(1).
   function automatic void build_frame(input int i, input logic [7:0] d,
                                       output logic [11:0] fr, output int len);
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = d;
`ifdef UART_TX_PARITY_EN
      fr[9] = (^d) ^ (i == 1);
`endif
      len = 1 + 8 + PAR_BITS + (i + 1);
   endfunction

   // One clock: drive baud_ce, advance, update model, compare all outputs.
   task automatic step();
      logic       bce;
      logic [1:0] acc;
      logic [2:0] e;
      bce = (ce_div <= 1) || (ce_cnt == ce_div - 1);
      baud_ce = bce;
      acc = tx_valid_a & ~exp_busy;
      @(posedge clk);
      #1;
      ce_cnt = (ce_cnt >= ce_div - 1) ? 0 : ce_cnt + 1;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            exp_q[i].delete();
            exp_tx[i] = 1'b1;
            exp_busy[i] = 1'b0;
         end else begin
            if (bce) begin
               baud_idx[i]++;
               if (exp_q[i].size() != 0) begin
                  e = exp_q[i].pop_front();
                  exp_tx[i] = e[0];
                  exp_busy[i] = e[1];
                  if (e[2]) start_q[i].push_back(baud_idx[i]);
               end
            end
            if (acc[i]) begin
               exp_busy[i] = 1'b1;
               accepted[i] = 1'b1;
               for (int b = 0; b < pend_len[i]; b++)
                  exp_q[i].push_back({b == 0, 1'b1, pend_frame[i][b]});
               exp_q[i].push_back(3'b001);
            end
         end
         chk("tx", i, int'(tx_w[i]), int'(exp_tx[i]));
         chk("busy", i, int'(busy_w[i]), int'(exp_busy[i]));
         chk("tx_ready", i, int'(ready_w[i]), int'(!exp_busy[i]));
         if (tx_w[i] == 1'b0) low_clks[i]++;
      end
   endtask

   // Offer the pending frame on instance i until the model sees the accept.
   task automatic offer(input int i, input logic [7:0] d);
      int n;
      accepted[i] = 1'b0;
      tx_valid_a[i] = 1'b1;
      tx_data_a[i] = d;
      n = 0;
      while (!accepted[i] && n < 200) begin
         step();
         n++;
      end
      if (!accepted[i]) chk("accept_timeout", i, 0, 1);
      tx_valid_a[i] = 1'b0;
      tx_data_a[i] = 8'($urandom);
   endtask

   // Run until instance i is idle; optional handshake noise while busy.
   task automatic wait_idle(input int i, input bit noise);
      int n;
      n = 0;
      while ((exp_busy[i] || exp_q[i].size() != 0) && n < 500) begin
         if (noise && exp_q[i].size() > 3) begin
            tx_valid_a[i] = 1'($urandom);
            tx_data_a[i] = 8'($urandom);
         end else begin
            tx_valid_a[i] = 1'b0;
         end
         step();
         n++;
      end
      if (n >= 500) chk("idle_timeout", i, 0, 1);
      step();
      chk("state_idle", i, int'(dbg_w[i]), int'(IDLE));
   endtask

   initial begin
      // ---------------- vector table ----------------
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{0, 8'h55, 4, {1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 24};
      vecs[1] = '{0, 8'h07, 4, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 24};
      vecs[2] = '{1, 8'h07, 4, {2'b11, 1'b0, 8'h07, 1'b0}, 12, 28};
      vecs[3] = '{1, 8'hFF, 4, {2'b11, 1'b1, 8'hFF, 1'b0}, 12, 4};
      vecs[4] = '{0, 8'h80, 1, {1'b0, 1'b1, 1'b1, 8'h80, 1'b0}, 11, 8};
      vecs[5] = '{1, 8'h3C, 3, {2'b11, 1'b1, 8'h3C, 1'b0}, 12, 15};
`else
      vecs[0] = '{0, 8'h55, 4, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 20};
      vecs[1] = '{0, 8'h07, 4, {2'b00, 1'b1, 8'h07, 1'b0}, 10, 24};
      vecs[2] = '{1, 8'h07, 4, {1'b0, 2'b11, 8'h07, 1'b0}, 11, 24};
      vecs[3] = '{1, 8'hFF, 4, {1'b0, 2'b11, 8'hFF, 1'b0}, 11, 4};
      vecs[4] = '{0, 8'h80, 1, {2'b00, 1'b1, 8'h80, 1'b0}, 10, 8};
      vecs[5] = '{1, 8'h3C, 3, {1'b0, 2'b11, 8'h3C, 1'b0}, 11, 15};
`endif
      for (int i = 0; i < 2; i++) begin
         baud_idx[i] = 0;
         low_clks[i] = 0;
         pend_frame[i] = '1;
         pend_len[i] = 0;
         accepted[i] = 1'b0;
      end

      // ---------------- reset ----------------
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("reset_state", 0, int'(dbg_w[0]), int'(IDLE));
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) step();

      // ---------------- table-driven frames ----------------
      for (int k = 0; k < 6; k++) begin
         ce_div = vecs[k].ce_div;
         pend_frame[vecs[k].inst] = vecs[k].frame;
         pend_len[vecs[k].inst] = vecs[k].len;
         low_clks[vecs[k].inst] = 0;
         offer(vecs[k].inst, vecs[k].data);
         wait_idle(vecs[k].inst, 1'b0);
         chk($sformatf("low_clks_v%0d", k), vecs[k].inst, low_clks[vecs[k].inst], vecs[k].exp_low);
      end

      // ---------------- back-to-back with tx_valid held ----------------
      ce_div = 4;
      start_q[0].delete();
      build_frame(0, 8'hA5, pend_frame[0], pend_len[0]);
      offer(0, 8'hA5);
      tx_valid_a[0] = 1'b1;
      tx_data_a[0] = 8'h3C;
      build_frame(0, 8'h3C, pend_frame[0], pend_len[0]);
      begin
         int n;
         accepted[0] = 1'b0;
         n = 0;
         while (!accepted[0] && n < 200) begin
            step();
            n++;
         end
         if (!accepted[0]) chk("b2b_accept_timeout", 0, 0, 1);
      end
      tx_valid_a[0] = 1'b0;
      wait_idle(0, 1'b0);
      chk("b2b_frames", 0, start_q[0].size(), 2);
      if (start_q[0].size() == 2)
         chk("b2b_start_gap", 0, start_q[0][1] - start_q[0][0], 1 + 8 + PAR_BITS + 1 + 1);

      // ---------------- reset during data bit 3 ----------------
      build_frame(0, 8'h5A, pend_frame[0], pend_len[0]);
      offer(0, 8'h5A);
      begin
         int n;
         n = 0;
         // start, d0, d1, d2, d3 popped -> d3 on the line
         while (exp_q[0].size() > pend_len[0] + 1 - 5 && n < 200) begin
            step();
            n++;
         end
         if (n >= 200) chk("bit3_timeout", 0, 0, 1);
      end
      step();
      step();
      reset_n = 1'b0;
      #1;
      chk("rst_tx", 0, int'(tx_w[0]), 1);
      chk("rst_busy", 0, int'(busy_w[0]), 0);
      chk("rst_ready", 0, int'(ready_w[0]), 1);
      step();
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) step();
      pend_frame[0] = vecs[0].frame;
      pend_len[0] = vecs[0].len;
      low_clks[0] = 0;
      offer(0, 8'h55);
      wait_idle(0, 1'b0);
      chk("post_reset_low", 0, low_clks[0], vecs[0].exp_low);

      // ---------------- randomized frames ----------------
      for (int k = 0; k < 40; k++) begin
         int i;
         logic [7:0] d;
         i = int'($urandom_range(0, 1));
         d = 8'($urandom);
         ce_div = int'($urandom_range(1, 5));
         for (int w = 0; w < int'($urandom_range(0, 5)); w++) step();
         build_frame(i, d, pend_frame[i], pend_len[i]);
         offer(i, d);
         wait_idle(i, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t expected=finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
